tbec_scrubber: RTL and testbench
================================

TBEC_SCRUBBER -- requirements
Module: tbec_scrubber

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 256: number of memory words scanned, addresses 0..NUM_WORDS-1.
REQ-002 SHALL have parameter ADDR_W, default 8: memory address width; NUM_WORDS <= 2**ADDR_W.
REQ-003 SHALL have port tbec_clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a full scan; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate the scan; honoured in any state other than IDLE.
REQ-007 SHALL have port mem_req  output  1  memory port request.
REQ-008 SHALL have port mem_gnt  input  1  memory port grant; an access occurs on an edge where mem_req and mem_gnt are both high.
REQ-009 SHALL have port mem_we  output  1  write enable; high only together with mem_req.
REQ-010 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-011 SHALL have port mem_wdata  output  32  codeword to write.
REQ-012 SHALL have port mem_rdata  input  32  read codeword; valid in the cycle after a granted read.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a scan completes.
REQ-015 SHALL have port corr_cnt  output  16  count of corrected words.
REQ-016 SHALL have port uncorr_cnt  output  16  count of uncorrectable words.
REQ-017 SHALL have port err_addr  output  ADDR_W  address of the most recent uncorrectable word.

Function
REQ-018 SHALL instantiate tbec_decoder on the captured read word and tbec_encoder on the decoder output; mem_wdata = encoder output.
REQ-019 SHALL decode error_code as: 00 clean; 01 single error corrected; 10 and 11 uncorrectable.
REQ-020 SHALL implement FSM states IDLE, RD, WAIT, CHK, WB, NEXT and DONE; all outputs registered or decoded from state only.
REQ-021 IDLE: on start=1 and abort=0, SHALL clear the address, corr_cnt, uncorr_cnt and err_addr, then go to RD.
REQ-022 RD: SHALL hold mem_req=1 and mem_we=0 with mem_addr equal to the current address; on mem_gnt=1 go to WAIT, otherwise stay in RD with all outputs stable.
REQ-023 WAIT: SHALL capture mem_rdata into the check register at the end of the cycle, with mem_req=0, then go to CHK.
REQ-024 CHK: on code 00 SHALL go to NEXT; on 01 SHALL go to WB; on 10/11 SHALL increment uncorr_cnt, load err_addr with the current address and go to NEXT.
REQ-025 WB: SHALL hold mem_req=1, mem_we=1 and mem_addr equal to the current address; on mem_gnt=1 SHALL increment corr_cnt and go to NEXT.
REQ-026 NEXT: if the address equals NUM_WORDS-1, SHALL go to DONE; otherwise SHALL increment the address and go to RD.
REQ-027 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE; busy=1 during DONE.
REQ-028 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-029 start while busy SHALL be ignored; start and abort together in IDLE: abort wins, FSM stays IDLE.
REQ-030 abort SHALL send the FSM to IDLE at the next edge with no done pulse; a write granted in that same edge completes; the counters keep their values.
REQ-031 With mem_gnt tied high, each clean word SHALL take exactly 4 cycles (RD, WAIT, CHK, NEXT) and each corrected word 5 cycles.

Reset
REQ-032 While rst=1, SHALL set the FSM to IDLE and drive mem_req=0, mem_we=0, mem_addr=0, mem_wdata from a zero check register, busy=0, done=0, corr_cnt=0, uncorr_cnt=0 and err_addr=0.
REQ-033 rst mid-scan SHALL abandon the scan immediately with no write issued on that edge; rst has priority over start and abort.

Verification
REQ-034 NUM_WORDS=4, all words clean, gnt=1, start at edge 0 -> busy=1 from cycle 1, no mem_we, done in cycle 17, counters 0.
REQ-035 Word 2 has a single bit flipped -> one write to address 2 with the correctly encoded original data, corr_cnt=1, done in cycle 18.
REQ-036 Word 1 has two bits flipped -> no write, uncorr_cnt=1, err_addr=1.
REQ-037 mem_gnt low for 5 cycles while in RD -> mem_req and mem_addr stay stable, the scan resumes after grant and the final counters are unchanged.
REQ-038 abort asserted in WAIT of word 2 -> IDLE next cycle, busy=0, no done pulse; a following start rescans from address 0 with counters cleared.
REQ-039 rst pulsed while in WB -> no write occurs and all outputs return to their reset values.

Source files
------------

// File: rtl/tbec_scrubber.sv
// Background memory scrubber: reads each word, SEC-DED checks it and writes back
// words that had a single correctable error. Encoder/decoder share one bit layout.

package tbec_scrubber_pkg;

    // Position of data bit k in the codeword: Hamming positions 1..31 that are not
    // powers of two, in ascending order. Bit 0 holds overall parity.
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned n;
        data_pos = 0;
        n = 0;
        for (int unsigned i = 3; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == k) begin
                    data_pos = i;
                end
                n++;
            end
        end
    endfunction

    // Codeword positions 1..31 whose index has bit k set (checked by parity bit 2**k).
    function automatic logic [31:0] cover_mask(input int unsigned k);
        cover_mask = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (((i >> k) & 1) != 0) begin
                cover_mask = cover_mask | (32'd1 << i);
            end
        end
    endfunction

endpackage

module tbec_encoder (
    input  logic [25:0] data,
    output logic [31:0] codeword
);
    logic [31:0] placed;
    logic [4:0]  parity;

    assign {placed[16], placed[8], placed[4], placed[2], placed[1], placed[0]} = 6'b0;

    for (genvar k = 0; k < 26; k++) begin : g_place
        assign placed[tbec_scrubber_pkg::data_pos(k)] = data[k];
    end

    for (genvar k = 0; k < 5; k++) begin : g_parity
        assign parity[k] = ^(placed & tbec_scrubber_pkg::cover_mask(k));
    end

    always_comb begin
        codeword     = placed;
        codeword[1]  = parity[0];
        codeword[2]  = parity[1];
        codeword[4]  = parity[2];
        codeword[8]  = parity[3];
        codeword[16] = parity[4];
        codeword[0]  = ^codeword[31:1];
    end
endmodule

module tbec_decoder (
    input  logic [31:0] codeword,
    output logic [25:0] data,
    output logic [1:0]  err_code
);
    logic [4:0]  syndrome;
    logic        parity;
    logic [31:0] fixed;

    for (genvar k = 0; k < 5; k++) begin : g_syndrome
        assign syndrome[k] = ^(codeword & tbec_scrubber_pkg::cover_mask(k));
    end

    assign parity = ^codeword;

    // Odd overall parity means one flipped bit at index syndrome (0 = the parity bit).
    always_comb begin
        fixed    = codeword;
        err_code = 2'b00;
        if (parity) begin
            fixed    = codeword ^ (32'd1 << syndrome);
            err_code = 2'b01;
        end else if (syndrome != 5'd0) begin
            err_code = 2'b10;
        end
    end

    for (genvar k = 0; k < 26; k++) begin : g_extract
        assign data[k] = fixed[tbec_scrubber_pkg::data_pos(k)];
    end
endmodule

module tbec_scrubber #(
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              tbec_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       corr_cnt,
    output logic [15:0]       uncorr_cnt,
    output logic [ADDR_W-1:0] err_addr
);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StChk,
        StWb,
        StNext,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       check_q, check_d;
    logic [15:0]       corr_q, corr_d;
    logic [15:0]       uncorr_q, uncorr_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic [31:0] dec_in;
    logic [25:0] dec_data;
    logic [1:0]  err_code;

    assign dec_in = rst ? 32'd0 : check_q;

    tbec_decoder u_decoder (
        .codeword (dec_in),
        .data     (dec_data),
        .err_code (err_code)
    );

    tbec_encoder u_encoder (
        .data     (dec_data),
        .codeword (mem_wdata)
    );

    always_ff @(posedge tbec_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            check_q    <= '0;
            corr_q     <= '0;
            uncorr_q   <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            check_q    <= check_d;
            corr_q     <= corr_d;
            uncorr_q   <= uncorr_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        check_d    = check_q;
        corr_d     = corr_q;
        uncorr_d   = uncorr_q;
        err_addr_d = err_addr_q;

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    addr_d     = '0;
                    corr_d     = '0;
                    uncorr_d   = '0;
                    err_addr_d = '0;
                    state_d    = StRd;
                end
            end
            StRd: begin
                if (mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                check_d = mem_rdata;
                state_d = StChk;
            end
            StChk: begin
                unique case (err_code)
                    2'b00: state_d = StNext;
                    2'b01: state_d = StWb;
                    default: begin
                        uncorr_d   = (uncorr_q == 16'hFFFF) ? uncorr_q : uncorr_q + 16'd1;
                        err_addr_d = addr_q;
                        state_d    = StNext;
                    end
                endcase
            end
            StWb: begin
                if (mem_gnt) begin
                    corr_d  = (corr_q == 16'hFFFF) ? corr_q : corr_q + 16'd1;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (addr_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StRd;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort leaves counters as they stood; a write granted on this edge still lands.
        if (abort && state_q != StIdle) begin
            state_d    = StIdle;
            corr_d     = corr_q;
            uncorr_d   = uncorr_q;
            err_addr_d = err_addr_q;
        end
    end

    // Gated by rst so nothing is requested or written on the reset edge itself.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        corr_cnt   = '0;
        uncorr_cnt = '0;
        err_addr   = '0;
        if (!rst) begin
            mem_req    = (state_q == StRd) || (state_q == StWb);
            mem_we     = (state_q == StWb);
            mem_addr   = addr_q;
            busy       = (state_q != StIdle);
            done       = (state_q == StDone);
            corr_cnt   = corr_q;
            uncorr_cnt = uncorr_q;
            err_addr   = err_addr_q;
        end
    end

endmodule

// File: tb/tb_tbec_scrubber.sv
// Self-checking bench for tbec_scrubber: a 4-word memory model, an independent
// SEC-DED reference encoder and per-scan expectations derived from word error kinds.

module tb_tbec_scrubber;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          tbec_clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          mem_req;
    logic          mem_gnt;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          done;
    logic [15:0]   corr_cnt;
    logic [15:0]   uncorr_cnt;
    logic [AW-1:0] err_addr;

    logic [31:0]   mem      [N];
    logic [31:0]   init_mem [N];
    logic [25:0]   orig     [N];
    int            kind     [N];   // 0 clean, 1 single flip, 2 double flip
    logic          load;
    int            n_writes;
    int            n_done;
    logic [AW-1:0] last_waddr;
    logic [31:0]   last_wdata;

    int checks   = 0;
    int failures = 0;
    int dc;

    tbec_scrubber #(
        .NUM_WORDS (N),
        .ADDR_W    (AW)
    ) dut (
        .tbec_clk   (tbec_clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .err_addr   (err_addr)
    );

    always #5 tbec_clk = ~tbec_clk;

    always @(posedge tbec_clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
            n_writes <= 0;
            n_done   <= 0;
        end else begin
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    mem[mem_addr] <= mem_wdata;
                    n_writes      <= n_writes + 1;
                    last_waddr    <= mem_addr;
                    last_wdata    <= mem_wdata;
                end else begin
                    mem_rdata <= mem[mem_addr];
                end
            end
            if (done) n_done <= n_done + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Data in non-power-of-two positions; parity bits set to the syndrome of the data
    // so the whole word XORs to index 0; bit 0 makes total parity even.
    function automatic logic [31:0] ref_encode(input logic [25:0] d);
        logic [31:0] c;
        logic [4:0]  s;
        int          j;
        c = '0;
        s = '0;
        j = 0;
        for (int p = 3; p < 32; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (((d >> j) & 26'd1) != 26'd0) begin
                    c = c | (32'd1 << p);
                    s = s ^ 5'(p);
                end
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (((s >> k) & 5'd1) != 5'd0) c = c | (32'd1 << (1 << k));
        end
        if ((^c) == 1'b1) c = c | 32'd1;
        return c;
    endfunction

    function automatic logic [31:0] corrupt(input logic [31:0] w, input int k);
        int unsigned a;
        int unsigned b;
        a = $urandom_range(31, 0);
        b = (a + $urandom_range(31, 1)) % 32;
        if (k == 1) return w ^ (32'd1 << a);
        if (k == 2) return w ^ (32'd1 << a) ^ (32'd1 << b);
        return w;
    endfunction

    task automatic build_mem();
        for (int i = 0; i < N; i++) begin
            orig[i]     = 26'($urandom);
            init_mem[i] = corrupt(ref_encode(orig[i]), kind[i]);
        end
        load = 1'b1;
        @(posedge tbec_clk);
        #1 load = 1'b0;
    endtask

    task automatic run_scan(input int gnt_low, input int extra_start_at, output int done_cyc);
        mem_gnt = (gnt_low == 0);
        start   = 1'b1;
        @(posedge tbec_clk);
        #1 start = 1'b0;
        done_cyc = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge tbec_clk);
            if (k == 1) begin
                check("busy_cycle1", busy, 1);
                check("counters_cleared", {corr_cnt, uncorr_cnt}, 0);
                check("err_addr_cleared", err_addr, 0);
            end
            if (gnt_low > 0 && k <= gnt_low + 1) begin
                check("rd_hold_req_we", {mem_req, mem_we}, 2'b10);
                check("rd_hold_addr", mem_addr, 0);
                if (k == gnt_low + 1) mem_gnt = 1'b1;
            end
            start = (k == extra_start_at);
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
        @(negedge tbec_clk);
        check("idle_after_done", {busy, done}, 2'b00);
    endtask

    task automatic check_results(input int gnt_low, input int done_cyc);
        int exp_corr;
        int exp_uncorr;
        int exp_err;
        exp_corr   = 0;
        exp_uncorr = 0;
        exp_err    = 0;
        for (int i = 0; i < N; i++) begin
            if (kind[i] == 1) exp_corr++;
            if (kind[i] == 2) begin
                exp_uncorr++;
                exp_err = i;
            end
        end
        check("done_cycle", done_cyc, 1 + 4 * N + exp_corr + gnt_low);
        check("corr_cnt", corr_cnt, exp_corr);
        check("uncorr_cnt", uncorr_cnt, exp_uncorr);
        check("err_addr", err_addr, exp_err);
        check("write_count", n_writes, exp_corr);
        check("done_pulses", n_done, 1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("mem_word%0d", i), mem[i],
                  (kind[i] == 2) ? init_mem[i] : ref_encode(orig[i]));
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        mem_gnt = 1'b1;
        load    = 1'b0;
        for (int i = 0; i < N; i++) kind[i] = 0;
        repeat (3) @(posedge tbec_clk);
        @(negedge tbec_clk);
        check("rst_req_we", {mem_req, mem_we}, 2'b00);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_counters", {corr_cnt, uncorr_cnt}, 0);
        check("rst_err_addr", err_addr, 0);
        rst = 1'b0;
        @(negedge tbec_clk);
        check("idle_busy", busy, 0);

        // All clean.
        build_mem();
        run_scan(0, 0, dc);
        check_results(0, dc);

        // Word 2 single-bit error.
        kind = '{0, 0, 1, 0};
        build_mem();
        run_scan(0, 0, dc);
        check_results(0, dc);
        check("wb_addr", last_waddr, 2);
        check("wb_data", last_wdata, ref_encode(orig[2]));

        // Word 1 double-bit error.
        kind = '{0, 2, 0, 0};
        build_mem();
        run_scan(0, 0, dc);
        check_results(0, dc);

        // start and abort together in IDLE: stays idle, counters untouched.
        start = 1'b1;
        abort = 1'b1;
        @(posedge tbec_clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge tbec_clk);
        check("start_abort_idle", busy, 0);
        check("start_abort_uncorr", uncorr_cnt, 1);

        // Grant withheld for 5 cycles in the first RD.
        for (int i = 0; i < N; i++) kind[i] = $urandom_range(2, 0);
        build_mem();
        run_scan(5, 0, dc);
        check_results(5, dc);

        // Random error mixes with a start pulse while busy.
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < N; i++) kind[i] = $urandom_range(2, 0);
            build_mem();
            run_scan(0, 6, dc);
            check_results(0, dc);
        end

        // Abort in WAIT of word 2 (cycle 10 with all words taking 4 cycles).
        kind = '{2, 0, 0, 0};
        build_mem();
        mem_gnt = 1'b1;
        start   = 1'b1;
        @(posedge tbec_clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge tbec_clk);
        check("wait_w2_req", mem_req, 0);
        check("wait_w2_addr", mem_addr, 2);
        abort = 1'b1;
        @(posedge tbec_clk);
        #1 abort = 1'b0;
        @(negedge tbec_clk);
        check("abort_idle", {busy, done}, 2'b00);
        check("abort_keeps_uncorr", uncorr_cnt, 1);
        repeat (4) @(negedge tbec_clk);
        check("abort_no_done", n_done, 0);
        run_scan(0, 0, dc);
        check_results(0, dc);

        // Reset pulsed while in WB of word 0 (RD, WAIT, CHK, WB = cycle 4).
        kind = '{1, 0, 0, 0};
        build_mem();
        mem_gnt = 1'b1;
        start   = 1'b1;
        @(posedge tbec_clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge tbec_clk);
        check("in_wb_we", {mem_req, mem_we}, 2'b11);
        rst = 1'b1;
        #1;
        check("rst_wb_req_we", {mem_req, mem_we}, 2'b00);
        @(posedge tbec_clk);
        #1 rst = 1'b0;
        @(negedge tbec_clk);
        check("rst_wb_no_write", n_writes, 0);
        check("rst_wb_mem0", mem[0], init_mem[0]);
        check("rst_wb_outputs", {mem_req, mem_we, busy, done}, 4'b0000);
        check("rst_wb_addr_wdata", {mem_addr, mem_wdata}, 0);
        check("rst_wb_counters", {corr_cnt, uncorr_cnt, err_addr}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
